pulse_count_arbiter: RTL and testbench

- Shares one count-transfer handshake (valid/count, ready/ack) between NUM_CH independent pulse sources in the source clock domain.
- Each channel accumulates single-cycle event pulses in a saturating counter.
- When downstream signals ready, a round-robin arbiter grants one channel with pending events. It presents that channel's count and ID, clears the counter, and holds valid until ack.
- ready and ack arrive as already-synchronized single-cycle pulses in this clock domain.

---
 rtl/pulse_count_arbiter_if.sv | 26 ++
 rtl/pulse_count_arbiter.sv | 135 +++++++++++++
 tb/tb_pulse_count_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_count_arbiter_if.sv
// rtl/pulse_count_arbiter_if.sv - pulse inputs and count-transfer handshake bundle
interface pulse_count_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] pulse_in;
    logic              ready;
    logic              ack;
    logic              valid;
    logic [CNT_W-1:0]  count;
    logic [ID_W-1:0]   ch_id;
    logic              sat;
    logic              busy;

    modport master (
        output pulse_in, ready, ack,
        input  valid, count, ch_id, sat, busy
    );

    modport slave (
        input  pulse_in, ready, ack,
        output valid, count, ch_id, sat, busy
    );
endinterface

// File: rtl/pulse_count_arbiter.sv
// rtl/pulse_count_arbiter.sv - per-channel saturating pulse counters shared over one round-robin transfer handshake
module pulse_count_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_count_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ID_W-1:0]  LAST_CH = ID_W'(NUM_CH - 1);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_inc [NUM_CH];
    logic [NUM_CH-1:0] sat_flag_q, sat_flag_d;
    logic [NUM_CH-1:0] at_max, req;
    logic              ready_pend_q, ready_pend_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ID_W-1:0]   ch_id_q, ch_id_d;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic              grant;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            at_max[i]  = (cnt_q[i] == CNT_MAX);
            cnt_inc[i] = (bus.pulse_in[i] && !at_max[i]) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
            req[i]     = (cnt_q[i] != '0) || bus.pulse_in[i];
        end
    end

    // Lowest requester overall, overridden by the lowest requester above last_grant.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last_grant_q))) begin
                gnt_idx = ID_W'(i);
            end
        end
    end

    assign grant = (state_q == IDLE) && (ready_pend_q || bus.ready) && gnt_found;

    always_comb begin
        state_d      = state_q;
        ready_pend_d = ready_pend_q | bus.ready;
        last_grant_d = last_grant_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        sat_d        = sat_q;
        count_d      = count_q;
        ch_id_d      = ch_id_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]      = cnt_inc[i];
            sat_flag_d[i] = sat_flag_q[i] | (bus.pulse_in[i] & at_max[i]);
        end

        case (state_q)
            IDLE: begin
                if (grant) begin
                    count_d             = cnt_inc[gnt_idx];
                    ch_id_d             = gnt_idx;
                    sat_d               = sat_flag_q[gnt_idx] | (bus.pulse_in[gnt_idx] & at_max[gnt_idx]);
                    cnt_d[gnt_idx]      = '0;
                    sat_flag_d[gnt_idx] = 1'b0;
                    valid_d             = 1'b1;
                    busy_d              = 1'b1;
                    last_grant_d        = gnt_idx;
                    ready_pend_d        = 1'b0;
                    state_d             = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.ack) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_pend_q <= 1'b0;
            last_grant_q <= LAST_CH;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            sat_q        <= 1'b0;
            count_q      <= '0;
            ch_id_q      <= '0;
            sat_flag_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ready_pend_q <= ready_pend_d;
            last_grant_q <= last_grant_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            sat_q        <= sat_d;
            count_q      <= count_d;
            ch_id_q      <= ch_id_d;
            sat_flag_q   <= sat_flag_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.sat   = sat_q;
    assign bus.count = count_q;
    assign bus.ch_id = ch_id_q;
endmodule

// File: tb/tb_pulse_count_arbiter.sv
// tb/tb_pulse_count_arbiter.sv - directed self-checking bench for pulse_count_arbiter
module tb_pulse_count_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pulse_count_arbiter_if #(.NUM_CH(4), .CNT_W(32)) bus ();
    pulse_count_arbiter_if #(.NUM_CH(4), .CNT_W(4))  bus4 ();

    pulse_count_arbiter #(.NUM_CH(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pulse_count_arbiter #(.NUM_CH(4), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.pulse_in  = '0; bus.ready  = 1'b0; bus.ack  = 1'b0;
        bus4.pulse_in = '0; bus4.ready = 1'b0; bus4.ack = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_n(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            bus.pulse_in = 4'(1 << ch);
            tick();
        end
        bus.pulse_in = '0;
    endtask

    task automatic ready_pulse();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.valid); end
        checks++;
        if (bus.count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++;
        if (bus.ch_id !== 2'd0) begin errors++; $display("FAIL reset_ch_id: got %0d expected 0", bus.ch_id); end
        checks++;
        if (bus.sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b expected 0", bus.sat); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        checks++;
        if (bus4.valid !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %0b expected 0", bus4.valid); end
        checks++;
    endtask

    task automatic test_single();
        do_reset();
        pulse_n(1, 5);
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_no_ready: got valid %0b expected 0", bus.valid); end
        checks++;
        ready_pulse();
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", bus.valid); end
        checks++;
        if (bus.ch_id !== 2'd1) begin errors++; $display("FAIL single_ch_id: got %0d expected 1", bus.ch_id); end
        checks++;
        if (bus.count !== 32'd5) begin errors++; $display("FAIL single_count: got %0d expected 5", bus.count); end
        checks++;
        if (bus.sat !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL single_sat_busy: got sat %0b busy %0b expected 0 1", bus.sat, bus.busy);
        end
        checks++;
        ack_pulse();
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_ack: got valid %0b busy %0b expected 0 0", bus.valid, bus.busy);
        end
        checks++;
        if (bus.count !== 32'd5) begin errors++; $display("FAIL single_count_hold: got %0d expected 5", bus.count); end
        checks++;
        ready_pulse();
        tick();
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_cleared: got valid %0b expected 0", bus.valid); end
        checks++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.pulse_in = 4'b0101;
            tick();
        end
        bus.pulse_in = '0;
        ready_pulse();
        if (bus.valid !== 1'b1 || bus.ch_id !== 2'd0 || bus.count !== 32'd3) begin
            errors++; $display("FAIL rr_first: got valid %0b ch %0d count %0d expected 1 0 3", bus.valid, bus.ch_id, bus.count);
        end
        checks++;
        ack_pulse();
        ready_pulse();
        if (bus.valid !== 1'b1 || bus.ch_id !== 2'd2 || bus.count !== 32'd3) begin
            errors++; $display("FAIL rr_second: got valid %0b ch %0d count %0d expected 1 2 3", bus.valid, bus.ch_id, bus.count);
        end
        checks++;
        ack_pulse();
    endtask

    task automatic test_pending_ready();
        do_reset();
        ready_pulse();
        tick();
        tick();
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL pend_zero: got valid %0b expected 0", bus.valid); end
        checks++;
        ack_pulse();
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL pend_idle_ack: got valid %0b busy %0b expected 0 0", bus.valid, bus.busy);
        end
        checks++;
        pulse_n(3, 1);
        if (bus.valid !== 1'b1 || bus.ch_id !== 2'd3 || bus.count !== 32'd1) begin
            errors++; $display("FAIL pend_late_pulse: got valid %0b ch %0d count %0d expected 1 3 1", bus.valid, bus.ch_id, bus.count);
        end
        checks++;
    endtask

    task automatic test_wait_ack_accum();
        do_reset();
        pulse_n(1, 2);
        ready_pulse();
        if (bus.count !== 32'd2 || bus.ch_id !== 2'd1) begin
            errors++; $display("FAIL wa_grant: got ch %0d count %0d expected 1 2", bus.ch_id, bus.count);
        end
        checks++;
        ready_pulse();
        pulse_n(1, 4);
        if (bus.valid !== 1'b1 || bus.count !== 32'd2) begin
            errors++; $display("FAIL wa_stable: got valid %0b count %0d expected 1 2", bus.valid, bus.count);
        end
        checks++;
        ack_pulse();
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL wa_ack: got valid %0b expected 0", bus.valid); end
        checks++;
        tick();
        if (bus.valid !== 1'b1 || bus.ch_id !== 2'd1 || bus.count !== 32'd4) begin
            errors++; $display("FAIL wa_regrant: got valid %0b ch %0d count %0d expected 1 1 4", bus.valid, bus.ch_id, bus.count);
        end
        checks++;
        pulse_n(0, 1);
        bus.ack = 1'b1; bus.ready = 1'b1;
        tick();
        bus.ack = 1'b0; bus.ready = 1'b0;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL wa_ack_ready: got valid %0b expected 0", bus.valid); end
        checks++;
        tick();
        if (bus.valid !== 1'b1 || bus.ch_id !== 2'd0 || bus.count !== 32'd1) begin
            errors++; $display("FAIL wa_next: got valid %0b ch %0d count %0d expected 1 0 1", bus.valid, bus.ch_id, bus.count);
        end
        checks++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            bus4.pulse_in = 4'b0001;
            tick();
        end
        bus4.pulse_in = '0;
        bus4.ready = 1'b1;
        tick();
        bus4.ready = 1'b0;
        if (bus4.valid !== 1'b1 || bus4.count !== 4'd15 || bus4.sat !== 1'b1) begin
            errors++; $display("FAIL sat_max: got valid %0b count %0d sat %0b expected 1 15 1", bus4.valid, bus4.count, bus4.sat);
        end
        checks++;
        bus4.ack = 1'b1;
        tick();
        bus4.ack = 1'b0;
        bus4.pulse_in = 4'b0001;
        tick();
        bus4.pulse_in = '0;
        bus4.ready = 1'b1;
        tick();
        bus4.ready = 1'b0;
        if (bus4.valid !== 1'b1 || bus4.count !== 4'd1 || bus4.sat !== 1'b0) begin
            errors++; $display("FAIL sat_clear: got valid %0b count %0d sat %0b expected 1 1 0", bus4.valid, bus4.count, bus4.sat);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_n(2, 7);
        ready_pulse();
        if (bus.valid !== 1'b1 || bus.ch_id !== 2'd2 || bus.count !== 32'd7) begin
            errors++; $display("FAIL rm_grant: got valid %0b ch %0d count %0d expected 1 2 7", bus.valid, bus.ch_id, bus.count);
        end
        checks++;
        rst = 1'b1;
        #1;
        if (bus.valid !== 1'b0 || bus.count !== 32'd0 || bus.ch_id !== 2'd0 || bus.busy !== 1'b0 || bus.sat !== 1'b0) begin
            errors++; $display("FAIL rm_async: got valid %0b count %0d ch %0d busy %0b sat %0b expected all 0",
                               bus.valid, bus.count, bus.ch_id, bus.busy, bus.sat);
        end
        checks++;
        tick();
        rst = 1'b0;
        ready_pulse();
        tick();
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL rm_no_transfer: got valid %0b expected 0", bus.valid); end
        checks++;
        pulse_n(2, 1);
        if (bus.valid !== 1'b1 || bus.count !== 32'd1) begin
            errors++; $display("FAIL rm_count_lost: got valid %0b count %0d expected 1 1", bus.valid, bus.count);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.pulse_in = 4'b1111;
        tick();
        bus.pulse_in = '0;
        for (int k = 0; k < 4; k++) begin
            ready_pulse();
            if (bus.valid !== 1'b1 || bus.ch_id !== 2'(k) || bus.count !== 32'd1) begin
                errors++; $display("FAIL b2b_grant%0d: got valid %0b ch %0d count %0d expected 1 %0d 1",
                                   k, bus.valid, bus.ch_id, bus.count, k);
            end
            checks++;
            ack_pulse();
        end
        ready_pulse();
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got valid %0b expected 0", bus.valid); end
        checks++;
    endtask

    initial begin
        bus.pulse_in  = '0; bus.ready  = 1'b0; bus.ack  = 1'b0;
        bus4.pulse_in = '0; bus4.ready = 1'b0; bus4.ack = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_pending_ready();
        test_wait_ack_accum();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
